alu_issue_queue: RTL

- Compacting, age-ordered issue queue that schedules renamed integer ops onto the single ALU.
- Holds up to DEPTH ops and tracks source readiness by snooping writeback physical-register tags.
- Each cycle it issues the oldest fully-ready op through a registered issue stage that feeds register read and the ALU's busA/busB/Conf/Pd/RegWr/tag_rob inputs.
- Flush from the back end empties it.

---
 rtl/alu_issue_queue.sv | 138 +++++++++++++
 1 files changed

// File: rtl/alu_issue_queue.sv
// Compacting, age-ordered issue queue feeding the single integer ALU.
// Oldest fully-ready op is issued through a registered stage; writeback tags wake sources.
module alu_issue_queue #(
  parameter int DEPTH = 8,
  parameter int PW    = 6,
  parameter int RW    = 6,
  parameter int NWB   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_back,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_Conf,
  input  logic [PW-1:0]              in_Pa,
  input  logic [PW-1:0]              in_Pb,
  input  logic                       in_rdyA,
  input  logic                       in_rdyB,
  input  logic [PW-1:0]              in_Pd,
  input  logic                       in_RegWr,
  input  logic [RW-1:0]              in_tag_rob,
  input  logic [NWB-1:0]             wb_valid,
  input  logic [NWB*PW-1:0]          wb_Pd,
  input  logic                       issue_stall,
  output logic                       issue_valid,
  output logic [3:0]                 issue_Conf,
  output logic [PW-1:0]              issue_Pa,
  output logic [PW-1:0]              issue_Pb,
  output logic [PW-1:0]              issue_Pd,
  output logic                       issue_RegWr,
  output logic [RW-1:0]              issue_tag_rob,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  typedef struct packed {
    logic [3:0]    conf;
    logic [PW-1:0] pa;
    logic [PW-1:0] pb;
    logic [PW-1:0] pd;
    logic          regwr;
    logic [RW-1:0] tag_rob;
    logic          rdya;
    logic          rdyb;
  } entry_t;

  entry_t        q   [DEPTH];
  entry_t        upd [DEPTH];
  entry_t        nxt [DEPTH];
  entry_t        new_entry;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] enq_idx;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          enq;

  // Tag 0 is the hardwired zero register and therefore always ready.
  function automatic logic hit(input logic [PW-1:0] p,
                               input logic [NWB-1:0] v,
                               input logic [NWB*PW-1:0] tags);
    logic h;
    h = (p == '0);
    for (int k = 0; k < NWB; k++) begin
      h = h | (v[k] & (tags[k*PW +: PW] == p));
    end
    return h;
  endfunction

  assign count    = count_q;
  assign in_ready = (count_q < CW'(DEPTH));
  assign enq      = in_valid & in_ready;
  assign enq_idx  = count_q - CW'(pick_any);

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    pick_any  = 1'b0;
    pick_idx  = '0;
    new_entry = '{conf: in_Conf, pa: in_Pa, pb: in_Pb, pd: in_Pd, regwr: in_RegWr,
                  tag_rob: in_tag_rob,
                  rdya: in_rdyA | hit(in_Pa, wb_valid, wb_Pd),
                  rdyb: in_rdyB | hit(in_Pb, wb_valid, wb_Pd)};
    for (int i = 0; i < DEPTH; i++) begin
      upd[i]      = q[i];
      upd[i].rdya = q[i].rdya | hit(q[i].pa, wb_valid, wb_Pd);
      upd[i].rdyb = q[i].rdyb | hit(q[i].pb, wb_valid, wb_Pd);
      if (!pick_any && !issue_stall && (CW'(i) < count_q) && upd[i].rdya && upd[i].rdyb) begin
        pick_any = 1'b1;
        pick_idx = IW'(i);
      end
    end

    // Entries above the picked slot slide down one, keeping their woken ready bits.
    for (int i = 0; i < DEPTH - 1; i++) begin
      nxt[i] = (pick_any && IW'(i) >= pick_idx) ? upd[i+1] : upd[i];
    end
    nxt[DEPTH-1] = upd[DEPTH-1];

    for (int i = 0; i < DEPTH; i++) begin
      if (enq && enq_idx == CW'(i)) nxt[i] = new_entry;
    end

    count_nxt = count_q - CW'(pick_any) + CW'(enq);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst || flush_back) begin
      count_q       <= '0;
      issue_valid   <= 1'b0;
      issue_Conf    <= '0;
      issue_Pa      <= '0;
      issue_Pb      <= '0;
      issue_Pd      <= '0;
      issue_RegWr   <= 1'b0;
      issue_tag_rob <= '0;
    end else begin
      count_q     <= count_nxt;
      issue_valid <= pick_any;
      if (pick_any) begin
        issue_Conf    <= upd[pick_idx].conf;
        issue_Pa      <= upd[pick_idx].pa;
        issue_Pb      <= upd[pick_idx].pb;
        issue_Pd      <= upd[pick_idx].pd;
        issue_RegWr   <= upd[pick_idx].regwr;
        issue_tag_rob <= upd[pick_idx].tag_rob;
      end
    end
  end

  // NOTE: entry payload is not reset; slots at or above count are never consulted.
  always_ff @(posedge clk) begin
    q <= nxt;
  end

endmodule
